// File: rtl/bus_arbiter2_32_pkg.sv
// Shared definitions for the two-requester bus arbiter: grant states,
// mux select encodings and the bus width.
package bus_arbiter2_32_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } arb_state_e;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  localparam int BUS_W = 32;

endpackage

// File: rtl/bus_arbiter2_32_mux.sv
// 32-bit two-input datapath mux shared by the requesters; sel = SEL_A picks a.
module bus_arbiter2_32_mux
  import bus_arbiter2_32_pkg::*;
(
  input  logic             sel,
  input  logic [BUS_W-1:0] a,
  input  logic [BUS_W-1:0] b,
  output logic [BUS_W-1:0] y
);

  assign y = (sel == SEL_A) ? a : b;

endmodule

// File: rtl/bus_arbiter2_32.sv
// Round-robin arbiter for two 32-bit requesters with locked bursts, feeding a
// single valid/ready output register toward the error-decoding pipeline.
module bus_arbiter2_32
  import bus_arbiter2_32_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CW        = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_a,
  input  logic             lock_a,
  input  logic [BUS_W-1:0] data_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic             lock_b,
  input  logic [BUS_W-1:0] data_b,
  output logic             ack_b,
  output logic             mux_sel,
  output logic             out_valid,
  output logic [BUS_W-1:0] out_data,
  input  logic             out_ready,
  output logic             grant_a,
  output logic             grant_b
);

  arb_state_e       state, state_nxt;
  logic [CW-1:0]    burst_cnt, burst_nxt;
  logic             prio_a, prio_nxt;
  logic             slot_free;
  logic [BUS_W-1:0] mux_out;
  logic [CW-1:0]    burst_inc;

  assign grant_a   = (state == GNT_A);
  assign grant_b   = (state == GNT_B);
  assign mux_sel   = grant_b ? SEL_B : SEL_A;
  assign slot_free = !out_valid || out_ready;
  assign ack_a     = grant_a && req_a && slot_free;
  assign ack_b     = grant_b && req_b && slot_free;
  assign burst_inc = (burst_cnt == {CW{1'b1}}) ? burst_cnt : burst_cnt + CW'(1);

  bus_arbiter2_32_mux u_mux (
    .sel (mux_sel),
    .a   (data_a),
    .b   (data_b),
    .y   (mux_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      burst_cnt <= '0;
      prio_a    <= 1'b1;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      prio_a    <= prio_nxt;
    end
  end

  // A locked owner keeps the bus until its burst budget runs out, but only
  // while the other side is actually waiting; stalls freeze everything.
  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (req_a && (!req_b || prio_a))
          state_nxt = GNT_A;
        else if (req_b)
          state_nxt = GNT_B;
      end
      GNT_A: begin
        if (ack_a) begin
          if (lock_a && ((burst_cnt < CW'(MAX_BURST - 1)) || !req_b)) begin
            burst_nxt = burst_inc;
          end else begin
            state_nxt = req_b ? GNT_B : GNT_A;
            burst_nxt = '0;
          end
        end else if (!req_a) begin
          state_nxt = req_b ? GNT_B : IDLE;
          burst_nxt = '0;
        end
      end
      GNT_B: begin
        if (ack_b) begin
          if (lock_b && ((burst_cnt < CW'(MAX_BURST - 1)) || !req_a)) begin
            burst_nxt = burst_inc;
          end else begin
            state_nxt = req_a ? GNT_A : GNT_B;
            burst_nxt = '0;
          end
        end else if (!req_b) begin
          state_nxt = req_a ? GNT_A : IDLE;
          burst_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        burst_nxt = '0;
      end
    endcase
  end

  // Priority points away from whoever was just granted, giving round-robin ties.
  always_comb begin
    prio_nxt = prio_a;
    if (state_nxt == GNT_A)
      prio_nxt = 1'b0;
    else if (state_nxt == GNT_B)
      prio_nxt = 1'b1;
  end

  // A drain and a new load in the same cycle keep out_valid high with no bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (ack_a || ack_b) begin
      out_valid <= 1'b1;
      out_data  <= mux_out;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_arbiter2_32.sv
// Randomized self-checking bench for bus_arbiter2_32 against a requester-indexed
// behavioural model of the arbitration and output-register rules.
module tb_bus_arbiter2_32;

  localparam int MAX_BURST = 4;
  localparam int NCYC      = 2000;

  logic        clk;
  logic        reset_n;
  logic        req_a, lock_a, ack_a;
  logic        req_b, lock_b, ack_b;
  logic [31:0] data_a, data_b;
  logic        mux_sel, out_valid, out_ready;
  logic [31:0] out_data;
  logic        grant_a, grant_b;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: owner -1 = nobody, 0 = A, 1 = B; prio names the tie winner.
  int          owner;
  int          burst;
  int          prio;
  bit          mv;
  logic [31:0] md;

  int mode;

  bus_arbiter2_32 #(.MAX_BURST(MAX_BURST), .CW(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_a     (req_a),
    .lock_a    (lock_a),
    .data_a    (data_a),
    .ack_a     (ack_a),
    .req_b     (req_b),
    .lock_b    (lock_b),
    .data_b    (data_b),
    .ack_b     (ack_b),
    .mux_sel   (mux_sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_a   (grant_a),
    .grant_b   (grant_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    owner = -1;
    burst = 0;
    prio  = 0;
    mv    = 1'b0;
    md    = '0;
  endtask

  task automatic applyStimulus(input int m);
    data_a = $urandom;
    data_b = $urandom;
    case (m)
      1: begin req_a = 1; req_b = 1; lock_a = 0; lock_b = 0; out_ready = 1; end
      2: begin req_a = 1; req_b = 1; lock_a = 1; lock_b = 1'($urandom % 2); out_ready = 1; end
      3: begin req_a = 1; req_b = 0; lock_a = 1; lock_b = 0; out_ready = ($urandom % 4) != 0; end
      4: begin
        req_a = ($urandom % 4) != 0; req_b = ($urandom % 4) != 0;
        lock_a = 1'($urandom % 2); lock_b = 1'($urandom % 2);
        out_ready = ($urandom % 3) == 0;
      end
      default: begin
        req_a = 1'($urandom % 2); req_b = 1'($urandom % 2);
        lock_a = 1'($urandom % 2); lock_b = 1'($urandom % 2);
        out_ready = 1'($urandom % 2);
      end
    endcase
  endtask

  // Compare DUT against the model for the current inputs, then advance the
  // model by one clock using the arbitration rules.
  task automatic modelCycle();
    bit          req [2];
    bit          lock [2];
    logic [31:0] data [2];
    bit          ack [2];
    bit          sf;
    int          nxt, x, o;
    req[0] = req_a;  req[1] = req_b;
    lock[0] = lock_a; lock[1] = lock_b;
    data[0] = data_a; data[1] = data_b;
    sf = !mv || out_ready;
    for (int i = 0; i < 2; i++) ack[i] = (owner == i) && req[i] && sf;

    checkOutput("grant_a", {31'd0, grant_a}, {31'd0, owner == 0});
    checkOutput("grant_b", {31'd0, grant_b}, {31'd0, owner == 1});
    checkOutput("mux_sel", {31'd0, mux_sel}, {31'd0, owner != 1});
    checkOutput("ack_a", {31'd0, ack_a}, {31'd0, ack[0]});
    checkOutput("ack_b", {31'd0, ack_b}, {31'd0, ack[1]});
    checkOutput("ack_exclusive", {31'd0, ack_a & ack_b}, 32'd0);
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, mv});
    checkOutput("out_data", out_data, md);

    nxt = owner;
    if (owner < 0) begin
      if (req[0] && req[1]) nxt = prio;
      else if (req[0]) nxt = 0;
      else if (req[1]) nxt = 1;
    end else begin
      x = owner;
      o = 1 - x;
      if (ack[x]) begin
        if (lock[x] && (burst < MAX_BURST - 1 || !req[o])) begin
          burst = (burst < 255) ? burst + 1 : 255;
        end else begin
          nxt = req[o] ? o : (req[x] ? x : -1);
          burst = 0;
        end
      end else if (!req[x]) begin
        nxt = req[o] ? o : -1;
        burst = 0;
      end
    end
    if (ack[0] || ack[1]) begin
      md = data[owner];
      mv = 1'b1;
    end else if (out_ready) begin
      mv = 1'b0;
    end
    if (nxt >= 0) prio = 1 - nxt;
    owner = nxt;
  endtask

  initial begin
    reset_n = 1'b0;
    req_a = 1; lock_a = 0; data_a = 32'hDEADBEEF;
    req_b = 0; lock_b = 0; data_b = 32'h0;
    out_ready = 1;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_grant_a", {31'd0, grant_a}, 32'd0);
    checkOutput("rst_grant_b", {31'd0, grant_b}, 32'd0);
    checkOutput("rst_ack_a", {31'd0, ack_a}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_mux_sel", {31'd0, mux_sel}, 32'd1);
    reset_n = 1'b1;

    // First word after reset: A alone with a known payload.
    for (int i = 0; i < 3; i++) begin
      modelCycle();
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("first_word", out_data, 32'hDEADBEEF);

    mode = 1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc % 40 == 0) mode = (cyc < 40) ? 1 : int'($urandom_range(0, 4));
      applyStimulus(mode);
      if (cyc % 400 == 200) begin
        #3 reset_n = 1'b0;
        #1;
        checkOutput("async_grant_a", {31'd0, grant_a}, 32'd0);
        checkOutput("async_grant_b", {31'd0, grant_b}, 32'd0);
        checkOutput("async_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("async_out_data", out_data, 32'd0);
        checkOutput("async_mux_sel", {31'd0, mux_sel}, 32'd1);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
      end else begin
        #1;
        modelCycle();
        @(posedge clk);
        @(negedge clk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
